// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: three sources (link, load, ALU) share one
// write port. Fixed priority lnk > ld > alu, with per-source aging so that a
// source waiting MAX_WAIT cycles becomes urgent and beats non-urgent ones.
// The write port itself is registered: a grant in cycle N drives rf_we in N+1.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned DROP_R0  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lnk_valid,
  output logic              lnk_ready,
  input  logic [DATA_W-1:0] lnk_pc,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned NSRC    = 3;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned SRC_LNK = 0;
  localparam int unsigned SRC_LD  = 1;
  localparam int unsigned SRC_ALU = 2;

  localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // One candidate write: destination register and data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic [NSRC-1:0]   valid_c;
  logic [NSRC-1:0]   urgent_c;
  logic [NSRC-1:0]   grant_c;
  logic              found_c;
  logic              any_grant_c;
  logic              drop_c;
  logic              stall_c;
  wb_req_t           req_c [NSRC];
  wb_req_t           sel_c;
  logic [WAIT_W-1:0] wait_q [NSRC];

  assign valid_c = {alu_valid, ld_valid, lnk_valid};

  // Normalise each source into an address/data pair; link writes PC+4 to the link register.
  always_comb begin
    req_c[SRC_LNK] = '{addr: ADDR_W'(LINK_REG), data: lnk_pc + DATA_W'(4)};
    req_c[SRC_LD]  = '{addr: ld_addr,  data: ld_data};
    req_c[SRC_ALU] = '{addr: alu_addr, data: alu_data};
  end

  // A valid source whose wait counter reached the limit is urgent.
  always_comb begin
    urgent_c = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      urgent_c[i] = valid_c[i] && (wait_q[i] == WAIT_SAT);
    end
  end

  // Urgent class first, then fixed priority by index; nothing is granted while in reset.
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!found_c && urgent_c[i]) begin
        grant_c[i] = 1'b1;
        found_c    = 1'b1;
      end
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!found_c && valid_c[i]) begin
        grant_c[i] = 1'b1;
        found_c    = 1'b1;
      end
    end
    grant_c = grant_c & {NSRC{rst_n}};
  end

  assign lnk_ready = grant_c[SRC_LNK];
  assign ld_ready  = grant_c[SRC_LD];
  assign alu_ready = grant_c[SRC_ALU];

  // Payload of the granted source (grant is one-hot or zero).
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (grant_c[i]) begin
        sel_c = req_c[i];
      end
    end
  end

  assign any_grant_c = |grant_c;
  assign drop_c      = (DROP_R0 != 0) && (sel_c.addr == '0);
  assign stall_c     = |(valid_c & ~grant_c);

  // Per-source aging: count cycles spent waiting, clear on grant or withdrawn request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSRC); i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (valid_c[i] && !grant_c[i]) begin
          wait_q[i] <= (wait_q[i] >= WAIT_SAT) ? WAIT_SAT : wait_q[i] + WAIT_W'(1);
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

  // Registered write port: one-cycle pulse after the grant; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= any_grant_c && !drop_c;
      if (any_grant_c) begin
        rf_waddr <= sel_c.addr;
        rf_wdata <= sel_c.data;
      end
    end
  end

  // Saturating count of cycles in which some requester was left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lnk_valid, ld_valid, alu_valid;
  logic        lnk_ready, ld_ready, alu_ready;
  logic [31:0] lnk_pc, ld_data, alu_data;
  logic [4:0]  ld_addr, alu_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;

  // Source-side stimulus: index 0 = link, 1 = load, 2 = ALU.
  logic        src_v [3];
  logic [4:0]  src_a [3];
  logic [31:0] src_d [3];

  // Reference model state.
  int          age [3];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          exp_stall;
  logic        hold_known;
  int          last_g;
  logic [2:0]  obs_rdy;

  int checks = 0;
  int errors = 0;

  assign lnk_valid = src_v[0];
  assign lnk_pc    = src_d[0];
  assign ld_valid  = src_v[1];
  assign ld_addr   = src_a[1];
  assign ld_data   = src_d[1];
  assign alu_valid = src_v[2];
  assign alu_addr  = src_a[2];
  assign alu_data  = src_d[2];

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .MAX_WAIT(MAX_WAIT), .DROP_R0(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_pc(lnk_pc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) age[i] = 0;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    exp_stall  = 0;
    hold_known = 1'b1;
  endtask

  // Winner by rule: oldest-class (age at limit) first, then link > load > ALU.
  function automatic int pick();
    int g = -1;
    for (int i = 0; i < 3; i++) if (g < 0 && src_v[i] && age[i] >= MAX_WAIT) g = i;
    for (int i = 0; i < 3; i++) if (g < 0 && src_v[i]) g = i;
    return g;
  endfunction

  // Check one cycle at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int         g;
    int         nvalid;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [2:0] exp_rdy;
    @(negedge clk);
    obs_rdy = {alu_ready, ld_ready, lnk_ready};
    g = -1;
    if (!rst_n) begin
      chk("rst_ready", 32'(obs_rdy), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
    end else begin
      g = pick();
      exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
      chk("ready", 32'(obs_rdy), 32'(exp_rdy));
      chk("rf_we", 32'(rf_we), 32'(exp_we));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (hold_known) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(exp_addr));
        chk("rf_wdata", rf_wdata, exp_data);
      end
      nvalid = 0;
      for (int i = 0; i < 3; i++) if (src_v[i]) nvalid++;
      if (nvalid > ((g >= 0) ? 1 : 0)) exp_stall = (exp_stall >= 65535) ? 65535 : exp_stall + 1;
      if (g >= 0) begin
        wa = (g == 0) ? 5'd31 : src_a[g];
        wd = (g == 0) ? src_d[0] + 32'd4 : src_d[g];
        exp_we = (wa != 5'd0);
        exp_addr = wa;
        exp_data = wd;
        hold_known = (wa != 5'd0);
      end else begin
        exp_we = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (src_v[i] && i != g) age[i] = (age[i] + 1 > MAX_WAIT) ? MAX_WAIT : age[i] + 1;
        else age[i] = 0;
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) src_v[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] aging_exp [5];
    int stall_base;
    aging_exp[0] = 3'b001; aging_exp[1] = 3'b001; aging_exp[2] = 3'b001;
    aging_exp[3] = 3'b010; aging_exp[4] = 3'b100;

    // Reset with every source requesting: nothing may be granted or written.
    for (int i = 0; i < 3; i++) begin
      src_v[i] = 1'b1;
      src_a[i] = 5'(i + 1);
      src_d[i] = 32'h100 * (i + 1);
    end
    #1 rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("first_grant_lnk", 32'(obs_rdy), 32'b001);
    idle_all();
    step();
    step();

    // Single ALU write with one-cycle latency and a single pulse.
    src_v[2] = 1'b1; src_a[2] = 5'd5; src_d[2] = 32'h0000_00AA;
    step();
    chk("alu_grant", 32'(obs_rdy), 32'b100);
    src_v[2] = 1'b0;
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h0000_00AA);
    step();
    chk("alu_we_drop", 32'(rf_we), 32'd0);
    step();
    chk("idle_hold_waddr", 32'(rf_waddr), 32'd5);

    // Link writes return address to r31, with wrap-around at the top of memory.
    src_v[0] = 1'b1; src_d[0] = 32'h0040_0010;
    step();
    src_d[0] = 32'hFFFF_FFFC;
    chk("lnk_waddr", 32'(rf_waddr), 32'd31);
    chk("lnk_wdata", rf_wdata, 32'h0040_0014);
    step();
    src_v[0] = 1'b0;
    chk("lnk_wrap_wdata", rf_wdata, 32'h0000_0000);
    chk("lnk_wrap_we", 32'(rf_we), 32'd1);
    step();

    // Aging: link keeps requesting, load and ALU get promoted and served in order.
    stall_base = exp_stall;
    src_v[0] = 1'b1; src_d[0] = 32'h0000_1000;
    src_v[1] = 1'b1; src_a[1] = 5'd3; src_d[1] = 32'h3333_0000;
    src_v[2] = 1'b1; src_a[2] = 5'd4; src_d[2] = 32'h4444_0000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("aging_grant%0d", k), 32'(obs_rdy), 32'(aging_exp[k]));
      if (obs_rdy[0]) src_d[0] = src_d[0] + 32'd8;
      if (obs_rdy[1]) src_v[1] = 1'b0;
      if (obs_rdy[2]) src_v[2] = 1'b0;
    end
    chk("aging_stall", 32'(stall_cnt), 32'(stall_base + 5));
    idle_all();
    step();
    step();

    // Register 0 write is acknowledged but never pulses the write enable.
    src_v[2] = 1'b1; src_a[2] = 5'd0; src_d[2] = 32'h0000_1234;
    step();
    chk("r0_grant", 32'(obs_rdy), 32'b100);
    src_v[2] = 1'b0;
    chk("r0_we", 32'(rf_we), 32'd0);
    step();

    // Reset between grant and write cycle drops the write; source retries afterwards.
    src_v[2] = 1'b1; src_a[2] = 5'd7; src_d[2] = 32'h0000_0077;
    #2;
    chk("midrst_grant", 32'(alu_ready), 32'd1);
    rst_n = 1'b0;
    model_reset();
    step();
    chk("midrst_we", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    step();
    chk("retry_grant", 32'(obs_rdy), 32'b100);
    src_v[2] = 1'b0;
    chk("retry_we", 32'(rf_we), 32'd1);
    chk("retry_waddr", 32'(rf_waddr), 32'd7);
    chk("retry_wdata", rf_wdata, 32'h0000_0077);
    step();

    // Random traffic: requests hold until granted, occasionally withdrawn.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_g == i) src_v[i] = 1'b0;
        if (src_v[i]) begin
          if ($urandom_range(0, 7) == 0) src_v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          src_v[i] = 1'b1;
          src_a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          src_d[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
